// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: default width plus encode/decode helpers
// sized for the widest legal counter (16 bits); narrower users zero-extend.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 16;

  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix-XOR from the MSB down; zero-extended inputs decode unchanged.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] gray);
    logic [GRAY_W_MAX-1:0] bin;
    bin[GRAY_W_MAX-1] = gray[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Purely combinational W-bit binary-to-Gray encoder; the inverse of the
// team's Gray-to-binary decoders.
module bin2gray_enc
  import gray_pkg::*;
#(
  parameter int W = GRAY_W_DEFAULT
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/bin2gray_counter.sv
// Up/down binary counter with a registered Gray output encoded from the next
// count. Define GRAY_CHECK_EN to add the sticky single-bit-step checker gray_err.
module bin2gray_counter
  import gray_pkg::*;
#(
  parameter int W = GRAY_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] load_bin,
  output logic [W-1:0] bin_q,
  output logic [W-1:0] gray_q,
  output logic         wrap
`ifdef GRAY_CHECK_EN
  ,
  output logic         gray_err
`endif
);

  logic [W-1:0] bin_next;
  logic [W-1:0] gray_next;
  logic         wrap_next;

  // Load beats count; wrap is flagged from the pre-step value at the boundary.
  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_bin;
    end else if (en) begin
      if (up_dn) begin
        bin_next  = bin_q + 1'b1;
        wrap_next = &bin_q;
      end else begin
        bin_next  = bin_q - 1'b1;
        wrap_next = ~|bin_q;
      end
    end
  end

  bin2gray_enc #(.W(W)) u_enc (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap   <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      wrap   <= wrap_next;
    end
  end

`ifdef GRAY_CHECK_EN
  logic [W-1:0] gray_prev;
  logic [W-1:0] gray_diff;
  logic         step_d;
  logic         one_bit;

  // A counting step registered on the last edge must differ from the value before it in one bit.
  assign gray_diff = gray_prev ^ gray_q;
  assign one_bit   = (gray_diff != '0) && ((gray_diff & (gray_diff - 1'b1)) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_prev <= '0;
      step_d    <= 1'b0;
      gray_err  <= 1'b0;
    end else begin
      gray_prev <= gray_q;
      step_d    <= ~load & en;
      if (step_d && !one_bit) begin
        gray_err <= 1'b1;
      end
    end
  end
`endif

endmodule
